multicycle_sequencer: RTL and testbench

Parametrised multicycle successor to the single-cycle control path of the RV64 core. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK phases and drives phase-qualified strobes to the datapath. Instruction and data memory use a variable-latency req/ack handshake with a timeout. The block decodes opcode, funct3 and instr[30], resolves branches from the ALU flags, traps on illegal opcodes and counts retired instructions.

---
 rtl/multicycle_pkg.sv | 70 +++++++
 rtl/multicycle_sequencer_decode_rom.sv | 88 ++++++++
 rtl/multicycle_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV64 control path.
// The ALU encoding is common with the single-cycle ControlUnit.
package multicycle_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP} state_t;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR_OP   = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // srcA: rs1 / PC / zero (LUI); writeback: ALU / memory / PC+4
  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_IMEM    = 2'd2;
  localparam logic [1:0] TRAP_DMEM    = 2'd3;

  typedef struct packed {
    logic [3:0] alu_control;
    logic [1:0] sel_src_a;
    logic       sel_src_b;
    logic [1:0] sel_writeback;
    logic       word;
    logic       load;
    logic       store;
    logic       branch;
    logic       jump;
    logic       jalr;
  } decode_t;

  // Carry=1 means no borrow, so unsigned less-than is !Carry
  function automatic logic branch_taken(input logic [2:0] funct3, input logic z,
                                        input logic n, input logic c, input logic v);
    case (funct3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n ^ v;
      3'b101:  return !(n ^ v);
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_decode_rom.sv
// Combinational instruction decode: opcode/funct3/instr[30] to datapath controls.
// The 32-bit word ops are only legal in a 64-bit build.
module decode_rom
  import multicycle_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output decode_t    dec,
  output logic       legal
);

  logic [3:0] alu_op;

  always_comb begin
    case (funct3)
      3'b000:  alu_op = ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OP: dec.alu_control = (funct3 == 3'b000 && funct7) ? ALU_SUB : alu_op;
      OP_32: begin
        legal           = (N == 64);
        dec.word        = 1'b1;
        dec.alu_control = (funct3 == 3'b000 && funct7) ? ALU_SUB : alu_op;
      end
      // For immediates instr[30] is an immediate bit except on right shifts
      OP_IMM: begin
        dec.alu_control = alu_op;
        dec.sel_src_b   = 1'b1;
      end
      OP_IMM_32: begin
        legal           = (N == 64);
        dec.word        = 1'b1;
        dec.alu_control = alu_op;
        dec.sel_src_b   = 1'b1;
      end
      LOAD: begin
        dec.sel_src_b     = 1'b1;
        dec.load          = 1'b1;
        dec.sel_writeback = WB_MEM;
      end
      STORE: begin
        dec.sel_src_b = 1'b1;
        dec.store     = 1'b1;
      end
      BRANCH: begin
        dec.alu_control = ALU_SUB;
        dec.branch      = 1'b1;
      end
      JAL: begin
        dec.sel_src_a     = SRCA_PC;
        dec.sel_src_b     = 1'b1;
        dec.sel_writeback = WB_PC4;
        dec.jump          = 1'b1;
      end
      JALR_OP: begin
        dec.sel_src_b     = 1'b1;
        dec.sel_writeback = WB_PC4;
        dec.jump          = 1'b1;
        dec.jalr          = 1'b1;
      end
      LUI: begin
        dec.sel_src_a = SRCA_ZERO;
        dec.sel_src_b = 1'b1;
      end
      AUIPC: begin
        dec.sel_src_a = SRCA_PC;
        dec.sel_src_b = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// req/ack memory handshakes, timeout traps and a retired-instruction counter.
module multicycle_sequencer
  import multicycle_pkg::*;
#(
  parameter int N           = 64,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             Zero,
  input  logic             Negative,
  input  logic             Carry,
  input  logic             Overflow,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             regWriteEnable,
  output logic             load,
  output logic             store,
  output logic             word,
  output logic [3:0]       ALUControl,
  output logic             JALR,
  output logic             sel_mux_pcnext,
  output logic             sel_mux_srcB,
  output logic [1:0]       sel_mux_srcA,
  output logic [1:0]       sel_mux_writeback,
  output logic             retired,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       trap_cause
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_reg, state_next;
  decode_t           dec_rom, dec_reg;
  logic              rom_legal;
  logic [2:0]        funct3_reg;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [1:0]        cause_reg, cause_next;
  logic [CNT_W-1:0]  instret_reg;
  logic              wait_expired;
  logic              bad_branch;

  decode_rom #(.N(N)) u_decode_rom (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .dec    (dec_rom),
    .legal  (rom_legal)
  );

  assign wait_expired = (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));
  assign bad_branch   = (funct3_reg[2:1] == 2'b01);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= FETCH;
      dec_reg     <= '0;
      funct3_reg  <= '0;
      wait_reg    <= '0;
      cause_reg   <= TRAP_NONE;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      cause_reg <= cause_next;
      if (state_next == TRAP) begin
        dec_reg <= '0;
      end else if (state_reg == DECODE) begin
        dec_reg    <= dec_rom;
        funct3_reg <= funct3;
      end
      if (retired) instret_reg <= instret_reg + 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_next      = wait_reg;
    cause_next     = cause_reg;
    imem_req       = 1'b0;
    ir_we          = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    pc_we          = 1'b0;
    regWriteEnable = 1'b0;
    retired        = 1'b0;
    sel_mux_pcnext = 1'b0;
    case (state_reg)
      FETCH: begin
        // Reset parks the state in FETCH, so the request is masked until release
        imem_req = rst;
        ir_we    = rst & imem_ack;
        if (imem_ack) begin
          wait_next  = '0;
          state_next = DECODE;
        end else if (wait_expired) begin
          wait_next  = '0;
          cause_next = TRAP_IMEM;
          state_next = TRAP;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      DECODE: begin
        if (rom_legal) begin
          state_next = EXECUTE;
        end else begin
          cause_next = TRAP_ILLEGAL;
          state_next = TRAP;
        end
      end
      EXECUTE: begin
        if (dec_reg.branch) begin
          if (bad_branch) begin
            cause_next = TRAP_ILLEGAL;
            state_next = TRAP;
          end else begin
            pc_we          = 1'b1;
            retired        = 1'b1;
            sel_mux_pcnext = branch_taken(funct3_reg, Zero, Negative, Carry, Overflow);
            state_next     = FETCH;
          end
        end else if (dec_reg.load || dec_reg.store) begin
          state_next = MEM;
        end else begin
          state_next = WRITEBACK;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_reg.store;
        if (dmem_ack) begin
          wait_next = '0;
          if (dec_reg.store) begin
            pc_we      = 1'b1;
            retired    = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WRITEBACK;
          end
        end else if (wait_expired) begin
          wait_next  = '0;
          cause_next = TRAP_DMEM;
          state_next = TRAP;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      WRITEBACK: begin
        regWriteEnable = 1'b1;
        pc_we          = 1'b1;
        retired        = 1'b1;
        sel_mux_pcnext = dec_reg.jump;
        state_next     = FETCH;
      end
      TRAP: state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

  assign load              = dec_reg.load;
  assign store             = dec_reg.store;
  assign word              = dec_reg.word;
  assign ALUControl        = dec_reg.alu_control;
  assign JALR              = dec_reg.jalr;
  assign sel_mux_srcA      = dec_reg.sel_src_a;
  assign sel_mux_srcB      = dec_reg.sel_src_b;
  assign sel_mux_writeback = dec_reg.sel_writeback;
  assign instret           = instret_reg;
  assign halted            = (state_reg == TRAP);
  assign trap_cause        = cause_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a default N=64 build plus an N=32 build
// with a 1-cycle memory timeout and 2-bit instret, driven by shared stimulus.
module tb_multicycle_sequencer;
  import multicycle_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7 = 1'b0;
  logic Zero = 1'b0, Negative = 1'b0, Carry = 1'b0, Overflow = 1'b0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0;

  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, regWriteEnable, load, store, word;
  logic JALR, sel_mux_pcnext, sel_mux_srcB, retired, halted;
  logic [3:0] ALUControl;
  logic [1:0] sel_mux_srcA, sel_mux_writeback, trap_cause;
  logic [31:0] instret;

  logic imem_req_n32, dmem_req_n32, dmem_we_n32, ir_we_n32, pc_we_n32, rwe_n32;
  logic load_n32, store_n32, word_n32, jalr_n32, pcnext_n32, srcb_n32, retired_n32, halted_n32;
  logic [3:0] alu_n32;
  logic [1:0] srca_n32, wb_n32, trap_cause_n32;
  logic [1:0] instret_n32;

  int checks_total = 0;
  int checks_passed = 0;
  int req_cnt, req_cnt_n32;

  always #5 clk = ~clk;

  multicycle_sequencer #(.N(64), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .regWriteEnable(regWriteEnable),
    .load(load), .store(store), .word(word), .ALUControl(ALUControl), .JALR(JALR),
    .sel_mux_pcnext(sel_mux_pcnext), .sel_mux_srcB(sel_mux_srcB),
    .sel_mux_srcA(sel_mux_srcA), .sel_mux_writeback(sel_mux_writeback),
    .retired(retired), .instret(instret), .halted(halted), .trap_cause(trap_cause)
  );

  multicycle_sequencer #(.N(32), .MEM_TIMEOUT(1), .CNT_W(2)) dut_n32 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req_n32), .dmem_req(dmem_req_n32),
    .dmem_we(dmem_we_n32), .ir_we(ir_we_n32), .pc_we(pc_we_n32), .regWriteEnable(rwe_n32),
    .load(load_n32), .store(store_n32), .word(word_n32), .ALUControl(alu_n32), .JALR(jalr_n32),
    .sel_mux_pcnext(pcnext_n32), .sel_mux_srcB(srcb_n32),
    .sel_mux_srcA(srca_n32), .sel_mux_writeback(wb_n32),
    .retired(retired_n32), .instret(instret_n32), .halted(halted_n32), .trap_cause(trap_cause_n32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Fetch with a zero-wait ack; returns one cycle later with the sequencer in DECODE
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    imem_ack = 1'b1;
    #1;
    check("fetch_req", imem_req, 1);
    tick();
    imem_ack = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with a stray ack that must be ignored
    imem_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_ir_we", ir_we, 0);
    check("rst_instret", instret, 0);
    check("rst_halted", halted, 0);
    check("rst_trap_cause", trap_cause, 0);
    $display("txn reset");

    // ADD, zero-wait: writeback strobes in cycle 3
    do_reset();
    issue(OP, 3'b000, 1'b0);
    check("add_decode_req", imem_req, 0);
    tick(); #1;
    check("add_alu", ALUControl, ALU_ADD);
    check("add_exec_rwe", regWriteEnable, 0);
    tick(); #1;
    check("add_wb_rwe", regWriteEnable, 1);
    check("add_wb_pcwe", pc_we, 1);
    check("add_wb_retired", retired, 1);
    tick(); #1;
    check("add_instret", instret, 1);
    check("add_refetch", imem_req, 1);
    $display("txn ADD");

    // LD with dmem_ack in the sixth request cycle
    do_reset();
    issue(LOAD, 3'b011, 1'b0);
    tick(); #1;
    check("ld_load", load, 1);
    tick();
    req_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      dmem_ack = (k == 5);
      #1;
      req_cnt += int'(dmem_req);
      if (k == 0) check("ld_we", dmem_we, 0);
      tick();
    end
    dmem_ack = 1'b0;
    #1;
    check("ld_req_cycles", req_cnt, 6);
    check("ld_wb_rwe", regWriteEnable, 1);
    check("ld_wb_sel", sel_mux_writeback, WB_MEM);
    check("n32_dmem_timeout", trap_cause_n32, TRAP_DMEM);
    tick(); #1;
    check("ld_instret", instret, 1);
    $display("txn LD");

    // BLT taken on N^V, BGEU not taken with Carry=0
    do_reset();
    issue(BRANCH, 3'b100, 1'b0);
    Negative = 1'b1; Overflow = 1'b0;
    tick(); #1;
    check("blt_taken", sel_mux_pcnext, 1);
    check("blt_pcwe", pc_we, 1);
    check("blt_rwe", regWriteEnable, 0);
    tick();
    issue(BRANCH, 3'b111, 1'b0);
    Carry = 1'b0;
    tick(); #1;
    check("bgeu_not_taken", sel_mux_pcnext, 0);
    check("bgeu_retired", retired, 1);
    tick(); #1;
    check("branch_instret", instret, 2);
    $display("txn BLT/BGEU");

    // Branch with funct3 010 is illegal
    do_reset();
    issue(BRANCH, 3'b010, 1'b0);
    tick(); #1;
    check("badbr_pcwe", pc_we, 0);
    tick(); #1;
    check("badbr_halted", halted, 1);
    check("badbr_cause", trap_cause, TRAP_ILLEGAL);
    check("badbr_instret", instret, 0);
    $display("txn bad branch");

    // Fetch timeout: imem_ack never arrives
    do_reset();
    opcode = OP;
    req_cnt = 0;
    req_cnt_n32 = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      req_cnt += int'(imem_req);
      req_cnt_n32 += int'(imem_req_n32);
      tick();
    end
    check("to_req_cycles", req_cnt, 16);
    check("to_req_cycles_n32", req_cnt_n32, 1);
    check("to_halted", halted, 1);
    check("to_cause", trap_cause, TRAP_IMEM);
    check("to_req_low", imem_req, 0);
    imem_ack = 1'b1;
    tick(); tick(); #1;
    check("trap_absorbing", halted, 1);
    check("trap_ir_we", ir_we, 0);
    check("trap_instret", instret, 0);
    $display("txn imem timeout");

    // OP-32 (ADDW): illegal at N=32, word op at N=64
    do_reset();
    issue(OP_32, 3'b000, 1'b0);
    tick(); #1;
    check("n32_halted", halted_n32, 1);
    check("n32_cause", trap_cause_n32, TRAP_ILLEGAL);
    check("n32_word_cleared", word_n32, 0);
    check("addw_word", word, 1);
    tick(); #1;
    check("addw_rwe", regWriteEnable, 1);
    check("n32_instret", instret_n32, 0);
    $display("txn ADDW");

    // JALR then LUI selects
    do_reset();
    issue(JALR_OP, 3'b000, 1'b0);
    tick(); #1;
    check("jalr_flag", JALR, 1);
    tick(); #1;
    check("jalr_wb_sel", sel_mux_writeback, WB_PC4);
    check("jalr_pcnext", sel_mux_pcnext, 1);
    tick();
    issue(LUI, 3'b000, 1'b0);
    tick(); #1;
    check("lui_srca", sel_mux_srcA, SRCA_ZERO);
    check("lui_jalr_clear", JALR, 0);
    $display("txn JALR/LUI");

    // instret wraps in the 2-bit build
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(OP, 3'b000, 1'b0);
      tick(); tick(); tick();
    end
    #1;
    check("wrap_instret64", instret, 4);
    check("wrap_instret_n32", instret_n32, 0);
    $display("txn instret wrap");

    // Store completes, then reset lands mid-MEM
    do_reset();
    issue(OP, 3'b000, 1'b0);
    tick(); tick(); tick();
    issue(STORE, 3'b011, 1'b0);
    tick(); tick();
    dmem_ack = 1'b1;
    #1;
    check("st_we", dmem_we, 1);
    check("st_retired", retired, 1);
    check("st_rwe", regWriteEnable, 0);
    tick();
    dmem_ack = 1'b0;
    #1;
    check("st_instret", instret, 2);
    issue(STORE, 3'b011, 1'b0);
    tick(); tick(); #1;
    check("mid_dmem_req", dmem_req, 1);
    rst = 1'b0;
    #1;
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_mid_instret", instret, 0);
    check("rst_mid_imem_req", imem_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("resume_fetch", imem_req, 1);
    $display("txn reset mid-MEM");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
